// File: rtl/ram_io_responder.sv
// Responder for the byte-serial memory bus: a byte RAM plus a memory-mapped I/O window
// holding RX/TX FIFOs to the host link, a status register and a sticky halt register.
module ram_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rw_req_in,
  input  logic [31:0] addr_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        rx_valid_in,
  input  logic [7:0]  rx_data_in,
  output logic        rx_ready_out,
  output logic        tx_valid_out,
  output logic [7:0]  tx_data_out,
  input  logic        tx_ready_in,
  output logic        io_full_out,
  output logic        halt_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [7:0]            mem_r    [0:(2**ADDR_WIDTH)-1];
  logic [7:0]            rx_buf_r [0:FIFO_DEPTH-1];
  logic [7:0]            tx_buf_r [0:FIFO_DEPTH-1];
  logic [PW:0]           rx_wp_r, rx_rp_r, tx_wp_r, tx_rp_r;
  logic                  rx_unf_r, tx_ovf_r, halt_r, prev_pop_rd_r;
  logic [7:0]            data_r;

  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic                  is_io_s;
  logic [3:0]            io_off_s;
  logic                  rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
  logic                  pop_rd_s, rx_pop_evt_s, rx_pop_s, rx_push_s;
  logic                  tx_push_evt_s, tx_push_s, tx_pop_s;
  logic                  io_rd_load_s;
  logic [7:0]            io_rdata_s;
  logic                  unused_s;

  assign unused_s   = ^addr_in[31:18];
  assign ram_addr_s = addr_in[ADDR_WIDTH-1:0];
  assign is_io_s    = (addr_in[17:16] == 2'b11);
  assign io_off_s   = addr_in[3:0];

  assign rx_empty_s = (rx_wp_r == rx_rp_r);
  assign rx_full_s  = (rx_wp_r[PW] != rx_rp_r[PW]) && (rx_wp_r[PW-1:0] == rx_rp_r[PW-1:0]);
  assign tx_empty_s = (tx_wp_r == tx_rp_r);
  assign tx_full_s  = (tx_wp_r[PW] != tx_rp_r[PW]) && (tx_wp_r[PW-1:0] == tx_rp_r[PW-1:0]);

  // A held read of the RX data port pops only on its first enabled cycle.
  assign pop_rd_s      = is_io_s && !rw_req_in && (io_off_s == 4'h0);
  assign rx_pop_evt_s  = rdy_in && pop_rd_s && !prev_pop_rd_r;
  assign rx_pop_s      = rx_pop_evt_s && !rx_empty_s;
  assign rx_push_s     = rx_valid_in && rx_ready_out;
  assign tx_push_evt_s = rdy_in && rw_req_in && is_io_s && (io_off_s == 4'h0);
  assign tx_push_s     = tx_push_evt_s && !tx_full_s;
  assign tx_pop_s      = tx_valid_out && tx_ready_in;

  assign rx_ready_out = rst_in && !rx_full_s;
  assign tx_valid_out = !tx_empty_s;
  assign tx_data_out  = tx_buf_r[tx_rp_r[PW-1:0]];
  assign io_full_out  = tx_full_s;
  assign halt_out     = halt_r;
  assign data_out     = data_r;

  // IO read data mux and whether this IO read updates data_out.
  always_comb begin
    io_rdata_s   = 8'h00;
    io_rd_load_s = 1'b1;
    case (io_off_s)
      4'h0: begin
        io_rd_load_s = rx_pop_evt_s;
        if (rx_empty_s) begin
          io_rdata_s = 8'h00;
        end else begin
          io_rdata_s = rx_buf_r[rx_rp_r[PW-1:0]];
        end
      end
      4'h4:    io_rdata_s = {4'b0000, tx_ovf_r, rx_unf_r, tx_full_s, rx_empty_s};
      default: io_rdata_s = 8'h00;
    endcase
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && rw_req_in && !is_io_s) begin
      mem_r[ram_addr_s] <= data_in;
    end
  end

  // Registered read data from RAM or the IO window.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      data_r <= 8'h00;
    end else if (rdy_in && !rw_req_in) begin
      if (!is_io_s) begin
        data_r <= mem_r[ram_addr_s];
      end else if (io_rd_load_s) begin
        data_r <= io_rdata_s;
      end
    end
  end

  // Sticky status flags, halt, and the pop edge detector.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rx_unf_r      <= 1'b0;
      tx_ovf_r      <= 1'b0;
      halt_r        <= 1'b0;
      prev_pop_rd_r <= 1'b0;
    end else if (rdy_in) begin
      prev_pop_rd_r <= pop_rd_s;
      if (rw_req_in && is_io_s && (io_off_s == 4'h8)) begin
        rx_unf_r <= 1'b0;
        tx_ovf_r <= 1'b0;
      end else begin
        if (rx_pop_evt_s && rx_empty_s) rx_unf_r <= 1'b1;
        if (tx_push_evt_s && tx_full_s) tx_ovf_r <= 1'b1;
      end
      if (rw_req_in && is_io_s && (io_off_s == 4'h4)) halt_r <= 1'b1;
    end
  end

  // FIFO pointers; reset discards all queued bytes.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rx_wp_r <= '0;
      rx_rp_r <= '0;
      tx_wp_r <= '0;
      tx_rp_r <= '0;
    end else begin
      if (rx_push_s) rx_wp_r <= rx_wp_r + PTR_ONE;
      if (rx_pop_s)  rx_rp_r <= rx_rp_r + PTR_ONE;
      if (tx_push_s) tx_wp_r <= tx_wp_r + PTR_ONE;
      if (tx_pop_s)  tx_rp_r <= tx_rp_r + PTR_ONE;
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk_in) begin
    if (rx_push_s) rx_buf_r[rx_wp_r[PW-1:0]] <= rx_data_in;
    if (tx_push_s) tx_buf_r[tx_wp_r[PW-1:0]] <= data_in;
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: expected bytes are queued as stimulus is
// driven and popped when the DUT output is sampled one clock later.
module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rw_req_in;
  logic [31:0] addr_in;
  logic [7:0]  data_in, data_out;
  logic        rx_valid_in, rx_ready_out;
  logic [7:0]  rx_data_in;
  logic        tx_valid_out, tx_ready_in, io_full_out, halt_out;
  logic [7:0]  tx_data_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx_m  [$];
  logic [7:0] tx_m  [$];
  logic [7:0] exp_v;

  always #5 clk_in = ~clk_in;

  ram_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rw_req_in(rw_req_in),
    .addr_in(addr_in), .data_in(data_in), .data_out(data_out),
    .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in), .rx_ready_out(rx_ready_out),
    .tx_valid_out(tx_valid_out), .tx_data_out(tx_data_out), .tx_ready_in(tx_ready_in),
    .io_full_out(io_full_out), .halt_out(halt_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cpu_set(input logic rw, input logic [31:0] a, input logic [7:0] d);
    rw_req_in = rw;
    addr_in   = a;
    data_in   = d;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rx_valid_in = 1'b1; rx_data_in = 8'hEE;
    cpu_set(1'b0, 32'h0003_0004, 8'h00);
    step(); step();
    checks++; if (rx_ready_out !== 1'b0) begin errors++; $display("FAIL rst_rx_ready: got %b expected 0", rx_ready_out); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", data_out); end
    checks++; if (halt_out !== 1'b0 || tx_valid_out !== 1'b0 || io_full_out !== 1'b0) begin
      errors++; $display("FAIL rst_flags: got halt=%b txv=%b full=%b expected 0 0 0", halt_out, tx_valid_out, io_full_out); end
    rx_valid_in = 1'b0; rst_in = 1'b1;
    exp_q.push_back(8'h01);
    step();
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL rst_status: got %h expected %h", data_out, exp_v); end
    checks++; if (rx_ready_out !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", rx_ready_out); end
  endtask

  task automatic test_ram();
    logic        rw_t  [6];
    logic [31:0] a_t   [6];
    logic [7:0]  d_t   [6];
    logic [7:0]  e_t   [6];
    rw_t = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    a_t  = '{32'h0003_0004, 32'h0000_0010, 32'h0000_0010, 32'h0002_0010, 32'h0001_FFFF, 32'h0001_FFFF};
    d_t  = '{8'h00, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00};
    e_t  = '{8'h01, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'h3C};
    for (int i = 0; i < 6; i++) begin
      cpu_set(rw_t[i], a_t[i], d_t[i]);
      exp_q.push_back(e_t[i]);
      step();
      exp_v = exp_q.pop_front();
      checks++; if (data_out !== exp_v) begin errors++; $display("FAIL ram_%0d: got %h expected %h", i, data_out, exp_v); end
    end
  endtask

  task automatic test_rx_pop();
    logic [7:0] last;
    cpu_set(1'b0, 32'h0003_0004, 8'h00);
    rx_valid_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rx_data_in = (i == 0) ? 8'h11 : 8'h22;
      if (rx_ready_out) rx_m.push_back(rx_data_in);
      step();
    end
    rx_valid_in = 1'b0;
    last = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cpu_set(1'b0, 32'h0003_0000, 8'h00);
      if (i == 0) last = rx_m.pop_front();
      exp_q.push_back(last);
      step();
      exp_v = exp_q.pop_front();
      checks++; if (data_out !== exp_v) begin errors++; $display("FAIL rx_hold_%0d: got %h expected %h", i, data_out, exp_v); end
    end
    cpu_set(1'b0, 32'h0003_0004, 8'h00); exp_q.push_back(8'h00); step();
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL rx_status_nonempty: got %h expected %h", data_out, exp_v); end
    cpu_set(1'b0, 32'h0003_0000, 8'h00); exp_q.push_back(rx_m.pop_front()); step();
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL rx_second_pop: got %h expected %h", data_out, exp_v); end
    cpu_set(1'b0, 32'h0003_0004, 8'h00); exp_q.push_back(8'h01); step();
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL rx_status_empty: got %h expected %h", data_out, exp_v); end
  endtask

  task automatic test_underflow();
    logic        rw_t [4];
    logic [31:0] a_t  [4];
    logic [7:0]  e_t  [4];
    rw_t = '{1'b0, 1'b0, 1'b1, 1'b0};
    a_t  = '{32'h0003_0000, 32'h0003_0004, 32'h0003_0008, 32'h0003_0004};
    e_t  = '{8'h00, 8'h05, 8'h05, 8'h01};
    for (int i = 0; i < 4; i++) begin
      cpu_set(rw_t[i], a_t[i], 8'hFF);
      exp_q.push_back(e_t[i]);
      step();
      exp_v = exp_q.pop_front();
      checks++; if (data_out !== exp_v) begin errors++; $display("FAIL underflow_%0d: got %h expected %h", i, data_out, exp_v); end
    end
  endtask

  task automatic test_tx_overflow();
    tx_ready_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cpu_set(1'b1, 32'h0003_0000, 8'h80 + 8'(i));
      if (tx_m.size() < 8) tx_m.push_back(8'h80 + 8'(i));
      step();
      checks++; if (io_full_out !== (tx_m.size() == 8)) begin
        errors++; $display("FAIL tx_full_%0d: got %b expected %b", i, io_full_out, (tx_m.size() == 8)); end
    end
    cpu_set(1'b0, 32'h0003_0004, 8'h00); exp_q.push_back(8'h0B); step();
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL tx_ovf_status: got %h expected %h", data_out, exp_v); end
    cpu_set(1'b1, 32'h0003_0008, 8'h00); step();
    cpu_set(1'b0, 32'h0003_0004, 8'h00); exp_q.push_back(8'h03); step();
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL tx_clear_status: got %h expected %h", data_out, exp_v); end
    tx_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_v = tx_m.pop_front();
      checks++; if (tx_valid_out !== 1'b1 || tx_data_out !== exp_v) begin
        errors++; $display("FAIL tx_drain_%0d: got v=%b %h expected v=1 %h", i, tx_valid_out, tx_data_out, exp_v); end
      step();
    end
    checks++; if (tx_valid_out !== 1'b0 || io_full_out !== 1'b0) begin
      errors++; $display("FAIL tx_drained: got v=%b full=%b expected 0 0", tx_valid_out, io_full_out); end
    tx_ready_in = 1'b0;
  endtask

  task automatic test_rx_full();
    cpu_set(1'b0, 32'h0003_0004, 8'h00);
    rx_valid_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data_in = 8'h40 + 8'(i);
      if (rx_ready_out) rx_m.push_back(rx_data_in);
      step();
    end
    checks++; if (rx_ready_out !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b expected 0", rx_ready_out); end
    cpu_set(1'b0, 32'h0003_0000, 8'h00);
    exp_q.push_back(rx_m.pop_front());
    step();
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL rx_full_pop: got %h expected %h", data_out, exp_v); end
    checks++; if (rx_ready_out !== 1'b1) begin errors++; $display("FAIL rx_ready_reopen: got %b expected 1", rx_ready_out); end
    cpu_set(1'b0, 32'h0003_0004, 8'h00);
    if (rx_ready_out) rx_m.push_back(rx_data_in);
    step();
    rx_valid_in = 1'b0;
    checks++; if (rx_ready_out !== 1'b0) begin errors++; $display("FAIL rx_refull: got %b expected 0", rx_ready_out); end
    for (int i = 0; i < 8; i++) begin
      cpu_set(1'b0, 32'h0003_0000, 8'h00); exp_q.push_back(rx_m.pop_front()); step();
      exp_v = exp_q.pop_front();
      checks++; if (data_out !== exp_v) begin errors++; $display("FAIL rx_drain_%0d: got %h expected %h", i, data_out, exp_v); end
      cpu_set(1'b0, 32'h0003_0004, 8'h00); exp_q.push_back((rx_m.size() == 0) ? 8'h01 : 8'h00); step();
      exp_v = exp_q.pop_front();
      checks++; if (data_out !== exp_v) begin errors++; $display("FAIL rx_drain_status_%0d: got %h expected %h", i, data_out, exp_v); end
    end
  endtask

  task automatic test_halt_rdy_reset();
    cpu_set(1'b1, 32'h0003_0004, 8'h00); step();
    checks++; if (halt_out !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", halt_out); end
    cpu_set(1'b0, 32'h0003_0004, 8'h00);
    step(); step(); step();
    checks++; if (halt_out !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", halt_out); end
    rdy_in = 1'b0;
    cpu_set(1'b1, 32'h0000_0010, 8'h77); exp_q.push_back(8'h01); step();
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL rdy_low_write_hold: got %h expected %h", data_out, exp_v); end
    rx_valid_in = 1'b1; rx_data_in = 8'h99;
    cpu_set(1'b0, 32'h0003_0000, 8'h00);
    if (rx_ready_out) rx_m.push_back(rx_data_in);
    exp_q.push_back(8'h01); step();
    rx_valid_in = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL rdy_low_no_pop: got %h expected %h", data_out, exp_v); end
    rdy_in = 1'b1;
    cpu_set(1'b0, 32'h0000_0010, 8'h00); exp_q.push_back(8'hA5); step();
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL rdy_low_ram_kept: got %h expected %h", data_out, exp_v); end
    cpu_set(1'b0, 32'h0003_0004, 8'h00); exp_q.push_back((rx_m.size() == 0) ? 8'h01 : 8'h00); step();
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL host_push_while_frozen: got %h expected %h", data_out, exp_v); end
    rst_in = 1'b0; step();
    checks++; if (halt_out !== 1'b0 || rx_ready_out !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL mid_reset: got halt=%b rdy=%b data=%h expected 0 0 00", halt_out, rx_ready_out, data_out); end
    rst_in = 1'b1; rx_m.delete();
    cpu_set(1'b0, 32'h0003_0004, 8'h00); exp_q.push_back(8'h01); step();
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v || tx_valid_out !== 1'b0) begin
      errors++; $display("FAIL post_reset_empty: got %h txv=%b expected %h txv=0", data_out, tx_valid_out, exp_v); end
    cpu_set(1'b0, 32'h0000_0010, 8'h00); exp_q.push_back(8'hA5); step();
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL ram_survives_reset: got %h expected %h", data_out, exp_v); end
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; rw_req_in = 1'b0; addr_in = 32'h0; data_in = 8'h00;
    rx_valid_in = 1'b0; rx_data_in = 8'h00; tx_ready_in = 1'b0;
    test_reset();
    test_ram();
    test_rx_pop();
    test_underflow();
    test_tx_overflow();
    test_rx_full();
    test_halt_rdy_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_io_responder.md
Name: ram_io_responder

Overview:
- Responder end of the byte-serial memory bus driven by mem_ctrl: one byte per cycle, rw_req = 1 for write, read data returned one cycle after the address.
- Contains a single-port byte RAM plus a memory-mapped I/O window.
- The I/O window has an RX FIFO fed by the host link, a TX FIFO drained by the host link, a status register and a halt register.
- Sits directly below mem_ctrl at the top level, replacing the bare RAM + I/O glue.

Parameters:
ADDR_WIDTH, 17, RAM holds 2^ADDR_WIDTH bytes, indexed by addr_in[ADDR_WIDTH-1:0]
FIFO_DEPTH, 8, entries per FIFO; power of two, >= 2

Ports:
clk_in  input  1  clock, all state on rising edge
rst_in  input  1  synchronous reset, active-low
rdy_in  input  1  CPU-side enable; low freezes CPU-side state (see Behaviour)
rw_req_in  input  1  1 = write this cycle, 0 = read
addr_in  input  32  byte address
data_in  input  8  write byte
data_out  output  8  read byte, registered
rx_valid_in  input  1  host offers byte
rx_data_in  input  8  host byte
rx_ready_out  output  1  RX FIFO accepts
tx_valid_out  output  1  TX FIFO non-empty
tx_data_out  output  8  TX FIFO head
tx_ready_in  input  1  host consumes head
io_full_out  output  1  TX FIFO full; upstream stalls on it
halt_out  output  1  sticky halt request

Behaviour:
- Reset, rst_in = 0 at a clock edge:
  - data_out = 0, halt_out = 0, both FIFOs empty, sticky flags cleared, edge-detect state cleared.
  - rx_ready_out = 0 while rst_in = 0.
  - RAM contents are not reset.
  - Reset mid-transfer discards all FIFO contents.
- Address decode: IO region when addr_in[17:16] == 2'b11 (0x30000 and up); otherwise RAM at addr_in[ADDR_WIDTH-1:0]. Addresses outside RAM wrap by truncation.
- RAM read: data_out <= RAM[addr] at the edge; visible the cycle after the address (1-cycle latency).
- RAM write: RAM[addr] <= data_in; data_out is unchanged on a write cycle. A write followed by a read of the same byte on the next cycle returns the new byte.
- IO map, offset = addr_in[3:0] within the IO region:
  - 0x0 read: pop RX FIFO head into data_out. If RX is empty, data_out = 0x00 and rx_underflow is set.
  - 0x0 write: push data_in to TX FIFO. If TX is full, the byte is dropped and tx_overflow is set.
  - 0x4 read: data_out = {4'b0, tx_overflow, rx_underflow, tx_full, rx_empty}; no side effect.
  - 0x4 write: halt_out <= 1, held until reset.
  - 0x8 write: clear rx_underflow and tx_overflow.
  - Any other IO read returns 0x00; any other IO write is ignored.
- Pop edge rule: an RX pop occurs only on a read of 0x30000 when the previous enabled cycle was not also a read of 0x30000. A held read address therefore pops exactly once; re-reading requires an intervening different access.
- rdy_in = 0 freezes all CPU-side state: no RAM write, no IO push/pop, data_out holds, edge-detect state holds, halt holds. Host-side FIFO handshakes continue.
- RX FIFO:
  - rx_ready_out = rst_in & !rx_full (rx_full registered).
  - Push when rx_valid_in & rx_ready_out.
  - Simultaneous host push and CPU pop is legal. On a full FIFO the push is refused that cycle because ready is low. On an empty FIFO the pop returns 0x00 with rx_underflow set, and the pushed byte is stored.
- TX FIFO:
  - tx_valid_out = !tx_empty, tx_data_out = head (combinational from storage).
  - Pop when tx_valid_out & tx_ready_in.
  - CPU push while full but with a same-cycle host pop is still dropped (full is evaluated before the edge).
  - io_full_out = tx_full.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ and remaining bits equal; empty = pointers equal.

Test Plan:
- Write 0xA5 to 0x00010 (rw=1), then read 0x00010 next cycle -> data_out = 0xA5 one cycle after the read address; read 0x20010 (wraps) -> 0xA5.
- Host pushes 0x11, 0x22; CPU holds a read of 0x30000 for 3 cycles -> exactly one pop, data_out = 0x11. Read 0x30004, then 0x30000 -> data_out = 0x22. Another read of 0x30004 -> 0x01 (rx_empty).
- Read 0x30000 with RX empty -> data_out = 0x00, status read = 0x05. Write 0x30008, then read status -> 0x01.
- 9 CPU writes to 0x30000 with tx_ready_in = 0 -> io_full_out rises after the 8th, the 9th byte is dropped, status bit 3 = 1. Raise tx_ready_in -> 8 bytes drained in order, one per cycle.
- Host holds rx_valid_in for 9 bytes without CPU reads -> rx_ready_out low after 8 accepted. One CPU pop -> ready high next cycle, 9th byte accepted.
- Write 0x30004 -> halt_out = 1 and stays 1. rdy_in = 0 during a RAM write of 0x77 -> RAM unchanged. rst_in = 0 for one cycle -> halt_out = 0, FIFOs empty, RAM retains data.
